// File: rtl/io_gpio_pkg.sv
// Shared constants for io_gpio: register map indices and address-field geometry.
package io_gpio_pkg;
   localparam int unsigned GPIO_BLK_LSB = 6;   // 64-byte block decode
   localparam int unsigned GPIO_IDX_W   = 4;

   localparam logic [GPIO_IDX_W-1:0] GPIO_OUT     = 4'd0;
   localparam logic [GPIO_IDX_W-1:0] GPIO_SET     = 4'd1;
   localparam logic [GPIO_IDX_W-1:0] GPIO_CLR     = 4'd2;
   localparam logic [GPIO_IDX_W-1:0] GPIO_TGL     = 4'd3;
   localparam logic [GPIO_IDX_W-1:0] GPIO_DIR     = 4'd4;
   localparam logic [GPIO_IDX_W-1:0] GPIO_IN      = 4'd5;
   localparam logic [GPIO_IDX_W-1:0] GPIO_RISE_EN = 4'd6;
   localparam logic [GPIO_IDX_W-1:0] GPIO_FALL_EN = 4'd7;
   localparam logic [GPIO_IDX_W-1:0] GPIO_FLAGS   = 4'd8;
endpackage

// File: rtl/io_gpio_sync.sv
// Pin synchroniser chain plus one-cycle-delayed copy for edge detection.
module io_gpio_sync #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_gpio,
   output logic [WIDTH-1:0] o_s,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall
);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_chain;
   logic [WIDTH-1:0]                  r_p;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_chain <= '0;
         r_p     <= '0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_gpio};
         r_p     <= r_chain[SYNC_STAGES-1];
      end
   end

   assign o_s    = r_chain[SYNC_STAGES-1];
   assign o_rise = o_s & ~r_p;
   assign o_fall = ~o_s & r_p;
endmodule

// File: rtl/io_gpio.sv
// Memory-mapped GPIO: decode, register file, registered read port and edge flags.
module io_gpio
   import io_gpio_pkg::*;
#(
   parameter int unsigned               WIDTH          = 8,
   parameter int unsigned               ADDR_BUS_WIDTH = 16,
   parameter logic [ADDR_BUS_WIDTH-1:0] BASE_ADDR      = 16'h0100,
   parameter int unsigned               SYNC_STAGES    = 2,
   parameter logic [WIDTH-1:0]          RESET_OUT      = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [ADDR_BUS_WIDTH-1:0] addr_i,
   input  logic [31:0]               data_i,
   input  logic                      wr_w_i,
   input  logic                      rd_w_i,
   output logic [31:0]               data_o,
   output logic                      data_rdy_o,
   input  logic [WIDTH-1:0]          gpio_i,
   output logic [WIDTH-1:0]          gpio_o,
   output logic [WIDTH-1:0]          gpio_oe_o,
   output logic                      int_o,
   input  logic                      int_ack_i
);
   logic [WIDTH-1:0] r_out, r_dir, r_rise_en, r_fall_en, r_flags;
   logic [31:0]      r_data;
   logic             r_rdy;

   logic                  w_sel, w_wr, w_rd;
   logic [GPIO_IDX_W-1:0] w_idx;
   logic [WIDTH-1:0]      w_wdata, w_s, w_rise, w_fall, w_clr;
   logic [31:0]           w_rdata;
   logic                  w_unused;

   io_gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_gpio  (gpio_i),
      .o_s     (w_s),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   assign w_sel   = (addr_i[ADDR_BUS_WIDTH-1:GPIO_BLK_LSB] == BASE_ADDR[ADDR_BUS_WIDTH-1:GPIO_BLK_LSB]);
   assign w_idx   = addr_i[GPIO_BLK_LSB-1:2];
   assign w_wr    = w_sel & wr_w_i;
   assign w_rd    = w_sel & rd_w_i;
   assign w_wdata = data_i[WIDTH-1:0];
   assign w_unused = &{1'b0, addr_i[1:0], data_i};

   // Ack clears everything; a FLAGS write clears the 1 bits. New edges win over clears.
   assign w_clr = ((w_wr && w_idx == GPIO_FLAGS) ? w_wdata : '0) | {WIDTH{int_ack_i}};

   always_comb begin
      w_rdata = '0;
      unique case (w_idx)
         GPIO_OUT, GPIO_SET, GPIO_CLR, GPIO_TGL: w_rdata[WIDTH-1:0] = r_out;
         GPIO_DIR:     w_rdata[WIDTH-1:0] = r_dir;
         GPIO_IN:      w_rdata[WIDTH-1:0] = w_s;
         GPIO_RISE_EN: w_rdata[WIDTH-1:0] = r_rise_en;
         GPIO_FALL_EN: w_rdata[WIDTH-1:0] = r_fall_en;
         GPIO_FLAGS:   w_rdata[WIDTH-1:0] = r_flags;
         default:      w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_out     <= RESET_OUT;
         r_dir     <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
         r_flags   <= '0;
         r_data    <= '0;
         r_rdy     <= 1'b0;
      end else begin
         r_rdy   <= w_rd;
         r_data  <= w_rd ? w_rdata : 32'd0;
         r_flags <= (r_flags & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
         if (w_wr) begin
            unique case (w_idx)
               GPIO_OUT:     r_out     <= w_wdata;
               GPIO_SET:     r_out     <= r_out | w_wdata;
               GPIO_CLR:     r_out     <= r_out & ~w_wdata;
               GPIO_TGL:     r_out     <= r_out ^ w_wdata;
               GPIO_DIR:     r_dir     <= w_wdata;
               GPIO_RISE_EN: r_rise_en <= w_wdata;
               GPIO_FALL_EN: r_fall_en <= w_wdata;
               default: ;
            endcase
         end
      end
   end

   assign data_o     = r_data;
   assign data_rdy_o = r_rdy;
   assign gpio_o     = r_out;
   assign gpio_oe_o  = r_dir;
   assign int_o      = |r_flags;
endmodule

// File: tb/tb_io_gpio.sv
// Randomised + directed bench for io_gpio against a register-level behavioural model.
module tb_io_gpio;
   localparam int W  = 8;
   localparam int SS = 2;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic [15:0] addr_i = '0;
   logic [31:0] data_i = '0;
   logic        wr_w_i = 1'b0, rd_w_i = 1'b0;
   logic [31:0] data_o;
   logic        data_rdy_o;
   logic [W-1:0] gpio_i = '0, gpio_o, gpio_oe_o;
   logic        int_o;
   logic        int_ack_i = 1'b0;

   int n_chk = 0, n_fail = 0;

   io_gpio #(.WIDTH(W), .ADDR_BUS_WIDTH(16), .BASE_ADDR(16'h0100),
             .SYNC_STAGES(SS), .RESET_OUT(8'hA5)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .addr_i(addr_i), .data_i(data_i),
      .wr_w_i(wr_w_i), .rd_w_i(rd_w_i), .data_o(data_o), .data_rdy_o(data_rdy_o),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o),
      .int_o(int_o), .int_ack_i(int_ack_i));

   always #5 clk_i = ~clk_i;

   // Model state: register values plus a history of sampled pin values.
   logic [W-1:0] m_out, m_dir, m_ren, m_fen, m_flags;
   logic [W-1:0] hist [0:SS];
   logic [31:0]  m_data;
   logic         m_rdy;

   function automatic logic [W-1:0] model_read(input int idx);
      case (idx)
         0, 1, 2, 3: return m_out;
         4: return m_dir;
         5: return hist[SS-1];
         6: return m_ren;
         7: return m_fen;
         8: return m_flags;
         default: return '0;
      endcase
   endfunction

   task automatic model_update();
      logic sel;
      int idx;
      logic [W-1:0] d, s, p, clr, nflags;
      if (!rst_i) begin
         m_out = 8'hA5; m_dir = '0; m_ren = '0; m_fen = '0; m_flags = '0;
         m_data = '0; m_rdy = 1'b0;
         for (int i = 0; i <= SS; i++) hist[i] = '0;
         return;
      end
      sel = (addr_i[15:6] == 10'h004);
      idx = int'(addr_i[5:2]);
      d   = data_i[W-1:0];
      s   = hist[SS-1];
      p   = hist[SS];
      m_rdy  = sel && rd_w_i;
      m_data = m_rdy ? {24'd0, model_read(idx)} : 32'd0;
      clr = (int_ack_i ? 8'hFF : 8'h00) | ((sel && wr_w_i && idx == 8) ? d : 8'h00);
      nflags = (m_flags & ~clr) | (s & ~p & m_ren) | (~s & p & m_fen);
      if (sel && wr_w_i) begin
         case (idx)
            0: m_out = d;
            1: m_out = m_out | d;
            2: m_out = m_out & ~d;
            3: m_out = m_out ^ d;
            4: m_dir = d;
            6: m_ren = d;
            7: m_fen = d;
            default: ;
         endcase
      end
      m_flags = nflags;
      for (int i = SS; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = gpio_i;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      model_update();
      #1;
      chk("data_o", data_o, m_data);
      chk("data_rdy_o", {31'd0, data_rdy_o}, {31'd0, m_rdy});
      chk("gpio_o", {24'd0, gpio_o}, {24'd0, m_out});
      chk("gpio_oe_o", {24'd0, gpio_oe_o}, {24'd0, m_dir});
      chk("int_o", {31'd0, int_o}, {31'd0, |m_flags});
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      addr_i = a; data_i = d; wr_w_i = 1'b1;
      step();
      wr_w_i = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a);
      addr_i = a; rd_w_i = 1'b1;
      step();
      rd_w_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b0;
      repeat (3) step();
      rst_i = 1'b1;
      chk("rst gpio_o", {24'd0, gpio_o}, 32'hA5);
      chk("rst gpio_oe_o", {24'd0, gpio_oe_o}, 32'h0);
      chk("rst int_o", {31'd0, int_o}, 32'h0);
      rd(16'h0100);
      chk("rd OUT data", data_o, 32'h0000_00A5);
      chk("rd OUT rdy", {31'd0, data_rdy_o}, 32'h1);
      step();
      chk("rdy one cycle", {31'd0, data_rdy_o}, 32'h0);

      wr(16'h0100, 32'h0F); chk("OUT", {24'd0, gpio_o}, 32'h0F);
      wr(16'h0104, 32'h30); chk("SET", {24'd0, gpio_o}, 32'h3F);
      wr(16'h0108, 32'h03); chk("CLR", {24'd0, gpio_o}, 32'h3C);
      wr(16'h010C, 32'hFF); chk("TGL", {24'd0, gpio_o}, 32'hC3);

      wr(16'h0200, 32'h00); chk("unsel wr", {24'd0, gpio_o}, 32'hC3);
      rd(16'h0200);
      chk("unsel rd data", data_o, 32'h0);
      chk("unsel rd rdy", {31'd0, data_rdy_o}, 32'h0);
      rd(16'h0120);
      chk("FLAGS rd idle", data_o, 32'h0);
      chk("FLAGS rd rdy", {31'd0, data_rdy_o}, 32'h1);

      wr(16'h0118, 32'h01);
      gpio_i[0] = 1'b1;
      step(); step();
      chk("rise early", {31'd0, int_o}, 32'h0);
      step();
      chk("rise int", {31'd0, int_o}, 32'h1);
      rd(16'h0120);
      chk("rise FLAGS", data_o, 32'h1);
      wr(16'h0120, 32'h01);
      chk("w1c int", {31'd0, int_o}, 32'h0);

      wr(16'h011C, 32'h02);
      gpio_i[1] = 1'b1;
      repeat (4) step();
      gpio_i[1] = 1'b0;
      step(); step();
      int_ack_i = 1'b1;
      step();
      int_ack_i = 1'b0;
      chk("ack vs edge int", {31'd0, int_o}, 32'h1);
      rd(16'h0120);
      chk("ack vs edge FLAGS", data_o, 32'h2);
      rd(16'h0114);
      chk("IN", data_o, 32'h1);

      addr_i = 16'h0100; rd_w_i = 1'b1; rst_i = 1'b0;
      step();
      rd_w_i = 1'b0; rst_i = 1'b1;
      chk("rst rd rdy", {31'd0, data_rdy_o}, 32'h0);
      chk("rst OUT", {24'd0, gpio_o}, 32'hA5);
      chk("rst int", {31'd0, int_o}, 32'h0);
      step();
      chk("rst rdy after", {31'd0, data_rdy_o}, 32'h0);

      for (int c = 0; c < 3000; c++) begin
         rst_i     = ($urandom_range(0, 299) != 0);
         addr_i    = ($urandom_range(0, 7) != 0) ? {10'h004, 4'($urandom_range(0, 15)), 2'b00}
                                                  : 16'($urandom);
         data_i    = $urandom;
         wr_w_i    = ($urandom_range(0, 2) == 0);
         rd_w_i    = ($urandom_range(0, 1) == 0);
         int_ack_i = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ 8'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
